// File: rtl/oversampling_sensor_pkg.sv
// Shared types and constants for the oversampling theremin sensor chain.
package oversampling_sensor_pkg;

  localparam int unsigned PKG_PERIOD_BITS        = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65536;

  typedef logic [PKG_PERIOD_BITS-1:0] period_t;

  typedef enum logic {
    FILLING,
    RUNNING
  } avg_state_e;

  // Window sum never overflows: 2^avg_log2 samples of period_bits each.
  function automatic int unsigned sum_width(input int unsigned period_bits,
                                            input int unsigned avg_log2);
    return period_bits + avg_log2;
  endfunction

endpackage

// File: rtl/period_window_ram.sv
// Circular sample buffer: synchronous write, asynchronous read (distributed RAM).
module period_window_ram #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/oversampling_period_averager.sv
// Sliding-window sum of the last 2^AVG_LOG2 period measurements, with
// loss-of-signal detection when samples stop arriving.
module oversampling_period_averager
  import oversampling_sensor_pkg::*;
#(
  parameter int unsigned PERIOD_BITS    = 16,
  parameter int unsigned AVG_LOG2       = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                         i_clk_parallel,
  input  logic                                         i_reset_n,
  input  logic                                         i_ce,
  input  logic                                         i_in_valid,
  input  logic [PERIOD_BITS-1:0]                       i_in_period,
  output logic                                         o_out_valid,
  output logic [sum_width(PERIOD_BITS, AVG_LOG2)-1:0]  o_out_sum,
  output logic                                         o_no_signal
);

  localparam int unsigned SUM_BITS  = sum_width(PERIOD_BITS, AVG_LOG2);
  localparam int unsigned DEPTH     = 1 << AVG_LOG2;
  localparam int unsigned IDLE_BITS = $clog2(TIMEOUT_CYCLES);

  localparam logic [AVG_LOG2:0]  FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0]  FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);
  localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(TIMEOUT_CYCLES - 1);

  logic [AVG_LOG2-1:0]    r_wptr;
  logic [AVG_LOG2:0]      r_fill;
  logic [SUM_BITS-1:0]    r_sum;
  logic [IDLE_BITS-1:0]   r_idle;
  logic                   r_fire;
  logic                   r_timeout;

  logic                   w_accept;
  logic                   w_expire;
  avg_state_e             w_state;
  logic [PERIOD_BITS-1:0] w_oldest;
  logic [SUM_BITS-1:0]    w_sum_next;

  period_window_ram #(
    .WIDTH     (PERIOD_BITS),
    .ADDR_BITS (AVG_LOG2)
  ) u_window (
    .i_clk   (i_clk_parallel),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (i_in_period),
    .i_raddr (r_wptr),
    .o_rdata (w_oldest)
  );

  assign w_state  = (r_fill == FILL_FULL) ? RUNNING : FILLING;
  assign w_accept = i_ce & i_in_valid;
  // A sample in the expiry cycle keeps the signal alive.
  assign w_expire = i_ce & ~i_in_valid & (r_idle == IDLE_LAST);

  // Stale entries left over from before a timeout are masked until refilled.
  assign w_sum_next = r_sum + SUM_BITS'(i_in_period)
                    - ((w_state == RUNNING) ? SUM_BITS'(w_oldest) : '0);

  always_ff @(posedge i_clk_parallel or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr      <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_idle      <= '0;
      r_fire      <= 1'b0;
      r_timeout   <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_sum   <= '0;
      o_no_signal <= 1'b1;
    end else begin
      r_fire    <= w_accept & ((w_state == RUNNING) | (r_fill == FILL_LAST));
      r_timeout <= w_expire;

      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
        r_sum  <= w_sum_next;
        r_idle <= '0;
        if (w_state == FILLING) begin
          r_fill <= r_fill + 1'b1;
        end
      end else if (w_expire) begin
        r_fill <= '0;
        r_sum  <= '0;
        r_idle <= '0;
      end else if (i_ce) begin
        r_idle <= r_idle + 1'b1;
      end

      // Output stage sits one register behind the running sum.
      o_out_valid <= r_fire;
      if (r_fire) begin
        o_out_sum   <= r_sum;
        o_no_signal <= 1'b0;
      end else if (r_timeout) begin
        o_out_sum   <= '0;
        o_no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oversampling_period_averager.sv
// Directed bench for the period averager (AVG_LOG2=4, TIMEOUT_CYCLES=100).
module tb_oversampling_period_averager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic [15:0] in_period;
  logic        out_valid;
  logic [19:0] out_sum;
  logic        no_signal;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  oversampling_period_averager #(
    .PERIOD_BITS    (16),
    .AVG_LOG2       (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clk_parallel (clk),
    .i_reset_n      (rst_n),
    .i_ce           (ce),
    .i_in_valid     (in_valid),
    .i_in_period    (in_period),
    .o_out_valid    (out_valid),
    .o_out_sum      (out_sum),
    .o_no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] p, input logic c);
    in_valid  = v;
    in_period = p;
    ce        = c;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) pulses++;
  endtask

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b0;
    in_valid  = 1'b0;
    in_period = '0;
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_sum", 32'(out_sum), 0);
    chk("reset_nosig", 32'(no_signal), 1);
    rst_n = 1'b1;

    // Initial fill with 1000
    pulses = 0;
    for (int i = 0; i < 16; i++) step(1, 16'd1000, 1);
    chk("fill_no_pulse", 32'(pulses), 0);
    chk("fill_nosig", 32'(no_signal), 1);
    step(0, 0, 1);
    chk("fill_valid", 32'(out_valid), 1);
    chk("fill_sum", 32'(out_sum), 16000);
    chk("fill_nosig_fall", 32'(no_signal), 0);
    step(0, 0, 1);
    chk("pulse_one_cycle", 32'(out_valid), 0);
    chk("sum_held", 32'(out_sum), 16000);

    // Replace oldest with 1016, then whole window
    step(1, 16'd1016, 1);
    step(0, 0, 1);
    chk("slide_sum", 32'(out_sum), 16016);
    pulses = 0;
    for (int i = 0; i < 16; i++) step(1, 16'd1016, 1);
    step(0, 0, 1);
    chk("slide_full_sum", 32'(out_sum), 16256);
    chk("slide_pulses", 32'(pulses), 16);

    // Max-value samples, checked every cycle
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      step(1, 16'hFFFF, 1);
      if (j >= 1) begin
        chk("max_ramp_sum", 32'(out_sum), 32'(1016 * (16 - j) + 65535 * j));
        chk("max_ramp_valid", 32'(out_valid), 1);
      end
    end
    step(0, 0, 1);
    chk("max_sum", 32'(out_sum), 32'h000FFFF0);
    chk("max_pulses", 32'(pulses), 16);

    // Sample exactly on idle cycle 100 keeps the signal alive
    step(1, 16'hFFFF, 1);
    for (int i = 0; i < 99; i++) step(0, 0, 1);
    step(1, 16'd0, 1);
    chk("late_nosig", 32'(no_signal), 0);
    step(0, 0, 1);
    chk("late_valid", 32'(out_valid), 1);
    chk("late_sum", 32'(out_sum), 32'h000EFFF1);
    chk("late_nosig2", 32'(no_signal), 0);

    // Genuine timeout: 100 idle cycles, visible on cycle 101
    for (int i = 0; i < 99; i++) step(0, 0, 1);
    chk("pre_to_nosig", 32'(no_signal), 0);
    chk("pre_to_sum", 32'(out_sum), 32'h000EFFF1);
    step(0, 0, 1);
    chk("to_nosig", 32'(no_signal), 1);
    chk("to_sum", 32'(out_sum), 0);

    // Refill after timeout: stale memory must not be subtracted
    pulses = 0;
    for (int i = 0; i < 15; i++) step(1, 16'd500, 1);
    chk("refill_no_pulse", 32'(pulses), 0);
    chk("refill_nosig", 32'(no_signal), 1);
    step(1, 16'd500, 1);
    step(0, 0, 1);
    chk("refill_valid", 32'(out_valid), 1);
    chk("refill_sum", 32'(out_sum), 8000);
    chk("refill_nosig_fall", 32'(no_signal), 0);

    // CE low: samples dropped, idle counter frozen
    pulses = 0;
    for (int i = 0; i < 50; i++) step(i[0], 16'd9999, 0);
    chk("ce_pulses", 32'(pulses), 0);
    chk("ce_sum", 32'(out_sum), 8000);
    chk("ce_nosig", 32'(no_signal), 0);
    for (int i = 0; i < 98; i++) step(0, 0, 1);
    chk("ce_idle_frozen", 32'(no_signal), 0);
    step(0, 0, 1);
    chk("ce_expire_edge", 32'(no_signal), 0);
    step(0, 0, 1);
    chk("ce_timeout_nosig", 32'(no_signal), 1);
    chk("ce_timeout_sum", 32'(out_sum), 0);

    // Reset mid-fill at FILL=7
    for (int i = 0; i < 7; i++) step(1, 16'd300, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_nosig", 32'(no_signal), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) step(1, 16'd200, 1);
    chk("postrst_no_pulse", 32'(pulses), 0);
    chk("postrst_nosig", 32'(no_signal), 1);
    step(1, 16'd200, 1);
    step(0, 0, 1);
    chk("postrst_valid", 32'(out_valid), 1);
    chk("postrst_sum", 32'(out_sum), 3200);

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #2;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_sum", 32'(out_sum), 0);
    chk("async_nosig", 32'(no_signal), 1);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
